// File: rtl/mem_bus_if.sv
// Initiator/responder bus for the line-oriented memory responder.
// The master modport is the initiator side; the slave modport is the responder side.
interface mem_bus_if #(
   parameter int ADDR_W = 6
);
   logic [1:0]        cmd_in;
   logic [ADDR_W-1:0] addr_in;
   logic [15:0]       data_in;
   logic [1:0]        cmd_out;
   logic [15:0]       data_out;
   logic              drv_en;
   logic              busy;
   logic              err;

   modport master (
      output cmd_in, addr_in, data_in,
      input  cmd_out, data_out, drv_en, busy, err
   );

   modport slave (
      input  cmd_in, addr_in, data_in,
      output cmd_out, data_out, drv_en, busy, err
   );
endinterface

// File: rtl/mem_bus_responder.sv
// Line-oriented memory responder: 8-beat line reads and writes with a fixed
// response latency, registered outputs, and storage that survives reset.
//
//   state         | meaning
//   --------------+--------------------------------------------------------
//   ST_IDLE       | waiting for a command; bus not driven
//   ST_WR_COLLECT | gathering write beats 1..7, line committed on beat 7
//   ST_WAIT       | latency down-counter running; responder drives NOP
//   ST_RESP       | RESPONSE cycles: 8 read beats, or 1 write acknowledge
module mem_bus_responder #(
   parameter int ADDR_W  = 6,
   parameter int LATENCY = 8,
   parameter int BEATS   = 8
) (
   input logic      clk,
   input logic      reset,
   mem_bus_if.slave bus
);
   localparam logic [1:0] CMD_NOP   = 2'd0;
   localparam logic [1:0] CMD_RESP  = 2'd1;
   localparam logic [1:0] CMD_READ  = 2'd2;
   localparam logic [1:0] CMD_WRITE = 2'd3;
   localparam int         LINE_W    = 16 * BEATS;
   localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);
   localparam logic [7:0] LAT_LOAD  = 8'(LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WR_COLLECT,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              op_wr_q, op_wr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [2:0]        beat_q, beat_d;
   logic [LINE_W-1:0] wr_line_q, wr_line_d;
   logic              mem_we;

   logic [1:0]        cmd_out_q, cmd_out_d;
   logic [15:0]       data_out_q, data_out_d;
   logic              drv_en_q, drv_en_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic [LINE_W-1:0] mem [2**ADDR_W];
   logic [LINE_W-1:0] rd_line;

   assign rd_line = mem[addr_q];

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      op_wr_d   = op_wr_q;
      cnt_d     = cnt_q;
      beat_d    = beat_q;
      wr_line_d = wr_line_q;
      mem_we    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            case (bus.cmd_in)
               CMD_READ: begin
                  addr_d  = bus.addr_in;
                  op_wr_d = 1'b0;
                  cnt_d   = LAT_LOAD;
                  beat_d  = 3'd0;
                  state_d = ST_WAIT;
               end
               CMD_WRITE: begin
                  addr_d          = bus.addr_in;
                  op_wr_d         = 1'b1;
                  wr_line_d[15:0] = bus.data_in;
                  beat_d          = 3'd1;
                  state_d         = ST_WR_COLLECT;
               end
               CMD_RESP: err_d = 1'b1;
               default: ;
            endcase
         end
         ST_WR_COLLECT: begin
            wr_line_d[{beat_q, 4'b0000} +: 16] = bus.data_in;
            if (beat_q == LAST_BEAT) begin
               // wr_line_d already holds the final beat, so the whole line commits now
               mem_we  = 1'b1;
               cnt_d   = LAT_LOAD;
               beat_d  = 3'd0;
               state_d = ST_WAIT;
            end else begin
               beat_d = beat_q + 3'd1;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               beat_d  = 3'd0;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (op_wr_q || beat_q == LAST_BEAT) begin
               beat_d  = 3'd0;
               state_d = ST_IDLE;
            end else begin
               beat_d = beat_q + 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are computed from the next state so they register alongside it
      cmd_out_d  = (state_d == ST_RESP) ? CMD_RESP : CMD_NOP;
      drv_en_d   = (state_d == ST_WAIT) || (state_d == ST_RESP);
      busy_d     = (state_d != ST_IDLE);
      data_out_d = (state_d == ST_RESP && !op_wr_d) ? rd_line[{beat_d, 4'b0000} +: 16] : 16'h0000;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         op_wr_q    <= 1'b0;
         cnt_q      <= 8'd0;
         beat_q     <= 3'd0;
         wr_line_q  <= '0;
         cmd_out_q  <= CMD_NOP;
         data_out_q <= 16'h0000;
         drv_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         op_wr_q    <= op_wr_d;
         cnt_q      <= cnt_d;
         beat_q     <= beat_d;
         wr_line_q  <= wr_line_d;
         cmd_out_q  <= cmd_out_d;
         data_out_q <= data_out_d;
         drv_en_q   <= drv_en_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   // Storage has no reset; a reset in the commit cycle drops the write
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[addr_q] <= wr_line_d;
      end
   end

   assign bus.cmd_out  = cmd_out_q;
   assign bus.data_out = data_out_q;
   assign bus.drv_en   = drv_en_q;
   assign bus.busy     = busy_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed plus randomized bench for mem_bus_responder, checked cycle by cycle
// against a line-array model of the expected bus behaviour.
module tb_mem_bus_responder;
   localparam int ADDR_W = 6;
   localparam int LAT    = 5;

   logic clk;
   logic reset;
   int   tests;
   int   failed;

   logic [15:0] model_mem [2**ADDR_W][8];
   int          wlist[$];

   mem_bus_if #(.ADDR_W(ADDR_W)) bus ();

   mem_bus_responder #(
      .ADDR_W (ADDR_W),
      .LATENCY(LAT),
      .BEATS  (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [20:0] ev(input logic [1:0] c, input logic [15:0] d,
                                      input logic drv, input logic bsy, input logic e);
      return {c, d, drv, bsy, e};
   endfunction

   function automatic logic [20:0] obs();
      return {bus.cmd_out, bus.data_out, bus.drv_en, bus.busy, bus.err};
   endfunction

   task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
      tests++;
      assert (got === exp)
      else begin
         failed++;
         $error("FAIL %s: got {cmd,data,drv,busy,err}=%h expected %h", tag, got, exp);
      end
   endtask

   task automatic garble();
      bus.cmd_in  = 2'($urandom_range(0, 3));
      bus.addr_in = ADDR_W'($urandom);
      bus.data_in = 16'($urandom);
   endtask

   task automatic remember(input int addr);
      foreach (wlist[i]) if (wlist[i] == addr) return;
      wlist.push_back(addr);
   endtask

   task automatic do_read(input int addr, input int abort_at);
      bus.cmd_in  = 2'd2;
      bus.addr_in = ADDR_W'(addr);
      bus.data_in = 16'($urandom);
      tick();
      for (int k = 0; k < LAT; k++) begin
         check($sformatf("rd_wait%0d a%0d", k, addr), obs(), ev(2'd0, 16'h0, 1'b1, 1'b1, 1'b0));
         garble();
         tick();
      end
      for (int b = 0; b < 8; b++) begin
         check($sformatf("rd_beat%0d a%0d", b, addr), obs(), ev(2'd1, model_mem[addr][b], 1'b1, 1'b1, 1'b0));
         if (b == abort_at) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check($sformatf("rd_abort%0d a%0d", b, addr), obs(), ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0));
            bus.cmd_in = 2'd0;
            return;
         end
         garble();
         tick();
      end
      check($sformatf("rd_idle a%0d", addr), obs(), ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0));
      bus.cmd_in = 2'd0;
   endtask

   task automatic do_write(input int addr, input logic [127:0] line, input int abort_at);
      bus.cmd_in  = 2'd3;
      bus.addr_in = ADDR_W'(addr);
      bus.data_in = line[15:0];
      tick();
      for (int k = 1; k < 8; k++) begin
         check($sformatf("wr_collect%0d a%0d", k, addr), obs(), ev(2'd0, 16'h0, 1'b0, 1'b1, 1'b0));
         garble();
         bus.data_in = line[16*k +: 16];
         if (k == abort_at) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check($sformatf("wr_abort%0d a%0d", k, addr), obs(), ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0));
            bus.cmd_in = 2'd0;
            return;
         end
         tick();
      end
      for (int k = 0; k < 8; k++) model_mem[addr][k] = line[16*k +: 16];
      remember(addr);
      for (int k = 0; k < LAT; k++) begin
         check($sformatf("wr_wait%0d a%0d", k, addr), obs(), ev(2'd0, 16'h0, 1'b1, 1'b1, 1'b0));
         garble();
         tick();
      end
      check($sformatf("wr_resp a%0d", addr), obs(), ev(2'd1, 16'h0, 1'b1, 1'b1, 1'b0));
      garble();
      tick();
      check($sformatf("wr_idle a%0d", addr), obs(), ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0));
      bus.cmd_in = 2'd0;
   endtask

   task automatic err_pulse();
      bus.cmd_in = 2'd1;
      tick();
      check("err_pulse", obs(), ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b1));
      bus.cmd_in = 2'd0;
      tick();
      check("err_clear", obs(), ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0));
   endtask

   initial begin
      logic [127:0] line;
      tests  = 0;
      failed = 0;

      reset       = 1'b1;
      bus.cmd_in  = 2'd0;
      bus.addr_in = '0;
      bus.data_in = 16'h0;
      tick();
      check("reset_state", obs(), ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0));

      bus.cmd_in = 2'd2;
      tick();
      check("reset_priority", obs(), ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0));
      reset      = 1'b0;
      bus.cmd_in = 2'd0;
      tick();
      check("idle_after_reset", obs(), ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0));

      err_pulse();

      for (int k = 0; k < 8; k++) line[16*k +: 16] = 16'h1110 + 16'(k);
      do_write(5, line, -1);
      do_read(5, -1);
      do_read(5, 3);
      do_read(5, -1);

      line = {8{16'hAAAA}};
      do_write(9, line, -1);
      line = {8{16'h5555}};
      do_write(9, line, 4);
      do_read(9, -1);

      for (int t = 0; t < 30; t++) begin
         int op;
         op = $urandom_range(0, 5);
         if (op <= 1 || wlist.size() == 0) begin
            for (int k = 0; k < 4; k++) line[32*k +: 32] = $urandom;
            do_write($urandom_range(0, 2**ADDR_W - 1), line,
                     ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : -1);
         end else if (op <= 4) begin
            do_read(wlist[$urandom_range(0, wlist.size() - 1)],
                    ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1);
         end else begin
            err_pulse();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter ADDR_W, default 6: line-address width; storage holds 2**ADDR_W lines.
REQ-002 Parameter LATENCY, default 8: idle cycles between command acceptance and the response phase; legal range 1..255.
REQ-003 Parameter BEATS, fixed 8: 16-bit beats per 128-bit line.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 cmd_in  in  2  initiator command: 0 NOP, 1 RESPONSE (reserved), 2 READ_LINE, 3 WRITE_LINE.
REQ-007 addr_in  in  ADDR_W  line address; valid in the command cycle only.
REQ-008 data_in  in  16  write beat from the initiator.
REQ-009 cmd_out  out  2  responder command: 0 NOP, 1 RESPONSE.
REQ-010 data_out  out  16  read beat to the initiator.
REQ-011 drv_en  out  1  high while the responder owns the bus (WAIT and RESP states).
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 err  out  1  one-cycle pulse on an illegal command.

Function
REQ-014 The FSM SHALL have states IDLE, WR_COLLECT, WAIT, RESP.
REQ-015 IDLE, cmd_in=2: latch addr_in, set op=READ, load counter=LATENCY, go to WAIT next cycle.
REQ-016 IDLE, cmd_in=3: latch addr_in, capture data_in as beat 0, set beat counter=1, go to WR_COLLECT.
REQ-017 WR_COLLECT: capture data_in as beat k every cycle for k=1..7, whatever cmd_in is; after beat 7, write the assembled line to storage in that cycle, load counter=LATENCY, go to WAIT.
REQ-018 Beat k SHALL occupy line bits [16k+15:16k] (beat 0 = least-significant halfword) for both reads and writes.
REQ-019 WAIT: decrement counter each cycle; cmd_out=NOP; data_out=0; when counter reaches 1, go to RESP next cycle, so RESP starts exactly LATENCY cycles after WAIT is entered.
REQ-020 RESP for READ: eight consecutive cycles with cmd_out=1 and data_out=beat 0..7 of the latched line, then IDLE.
REQ-021 RESP for WRITE: exactly one cycle with cmd_out=1 and data_out=0, then IDLE.
REQ-022 Read latency: first read beat appears LATENCY+1 cycles after the posedge that samples READ_LINE.
REQ-023 IDLE, cmd_in=1: no state change; err=1 for the following cycle.
REQ-024 cmd_in is ignored in WAIT and RESP; cmd_in is ignored in WR_COLLECT apart from data capture.
REQ-025 A command in the first IDLE cycle after RESP SHALL be accepted; back-to-back transactions have no dead cycle.
REQ-026 A read of a line written in a completed earlier transaction SHALL return the written data.
REQ-027 Storage is never read and written in the same cycle; contents are undefined until first written.
REQ-028 Outputs SHALL be registered; drv_en=1 exactly in WAIT and RESP; busy=0 exactly in IDLE.

Reset
REQ-029 With reset=1 at posedge: state=IDLE, cmd_out=0, data_out=0, drv_en=0, busy=0, err=0, all counters=0.
REQ-030 Reset in any state, including mid-burst, SHALL abort the transaction with no further RESPONSE cycles.
REQ-031 Reset SHALL NOT clear storage; a WRITE aborted in WR_COLLECT SHALL leave the target line unmodified.
REQ-032 Reset has priority over a simultaneous cmd_in.

Verification
REQ-033 WRITE_LINE addr=5, beats 16'h1110..16'h1117 -> one RESPONSE cycle at cycle 8+LATENCY after the command cycle; busy falls the cycle after.
REQ-034 READ_LINE addr=5 after REQ-033 -> cmd_out=1 for 8 cycles, data_out 16'h1110..16'h1117 in order, first beat LATENCY+1 cycles after the command.
REQ-035 READ_LINE issued on the first IDLE cycle after a WRITE response -> accepted in that cycle, no lost command.
REQ-036 reset asserted during RESP beat 3 of a read -> next cycle cmd_out=0, drv_en=0, busy=0; a re-read of the same line returns the full correct line.
REQ-037 reset asserted during WR_COLLECT beat 4 to addr=9 holding 16'hAAAA pattern -> a later read of addr=9 returns 16'hAAAA for all beats.
REQ-038 cmd_in=1 in IDLE -> err=1 for one cycle; state stays IDLE; cmd_out stays 0.
